// File: rtl/uart_rx_cozucu.sv
// uart_rx_cozucu: UART frame decoder with mid-bit sampling, optional parity, valid/ready output
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   baud_div_i               clocks per bit (values below 4 act as 4), captured at start edge
//   eslik_en_i, eslik_tek_i  parity enable / odd select, captured at start edge
//   rx_i                     asynchronous serial line, idle high
//   veri_o, veri_gecerli_o,  received byte and its valid flag, released by veri_hazir_i
//   veri_hazir_i
//   cerceve_hata_o           1-cycle pulse: stop bit sampled low
//   eslik_hata_o             1-cycle pulse: parity mismatch
//   tasma_o                  1-cycle pulse: byte lost because previous one still pending
//   mesgul_o                 receiver busy with a frame
module uart_rx_cozucu #(
    parameter int SYNC_STAGES  = 2,
    parameter int KARAKTER_BIT = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [15:0]             baud_div_i,
    input  logic                    eslik_en_i,
    input  logic                    eslik_tek_i,
    input  logic                    rx_i,
    output logic [KARAKTER_BIT-1:0] veri_o,
    output logic                    veri_gecerli_o,
    input  logic                    veri_hazir_i,
    output logic                    cerceve_hata_o,
    output logic                    eslik_hata_o,
    output logic                    tasma_o,
    output logic                    mesgul_o
);
    localparam int IW = KARAKTER_BIT > 1 ? $clog2(KARAKTER_BIT) : 1;

    typedef enum logic [2:0] {BOSTA, BASLA, VERI, ESLIK, DUR} durum_t;

    durum_t                  durum, durum_n;
    logic [SYNC_STAGES-1:0]  sync;
    logic                    rx_s, rx_d;
    logic [15:0]             sayac, bolen, d_eff;
    logic                    en_r, tek_r, par_bit;
    logic [IW-1:0]           bit_idx;
    logic [KARAKTER_BIT-1:0] veri_sh;
    logic                    tick, bas_kenar, son_bit, bitis, par_ok, bekleyen;
    logic                    ce, pe, ov, yukle;

    assign rx_s      = sync[SYNC_STAGES-1];
    assign d_eff     = baud_div_i < 16'd4 ? 16'd4 : baud_div_i;
    assign tick      = (durum != BOSTA) && (sayac == 16'd0);
    assign bas_kenar = (durum == BOSTA) && rx_d && !rx_s;
    assign son_bit   = bit_idx == IW'(KARAKTER_BIT - 1);
    assign mesgul_o  = durum != BOSTA;

    // Stop-sample outcome, first matching rule wins: framing, parity, overrun, load.
    assign bitis    = (durum == DUR) && tick;
    assign par_ok   = !en_r || (par_bit == (^veri_sh ^ tek_r));
    assign bekleyen = veri_gecerli_o && !veri_hazir_i;
    assign ce       = bitis && !rx_s;
    assign pe       = bitis && rx_s && !par_ok;
    assign ov       = bitis && rx_s && par_ok && bekleyen;
    assign yukle    = bitis && rx_s && par_ok && !bekleyen;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum <= BOSTA;
            sync  <= '1;
            rx_d  <= 1'b1;
        end else begin
            durum <= durum_n;
            sync  <= {sync[SYNC_STAGES-2:0], rx_i};
            rx_d  <= rx_s;
        end
    end

    always_comb begin
        durum_n = durum;
        case (durum)
            BOSTA:   durum_n = bas_kenar ? BASLA : BOSTA;
            BASLA:   durum_n = !tick ? BASLA : (rx_s ? BOSTA : VERI);
            VERI:    durum_n = !(tick && son_bit) ? VERI : (en_r ? ESLIK : DUR);
            ESLIK:   durum_n = tick ? DUR : ESLIK;
            DUR:     durum_n = tick ? BOSTA : DUR;
            default: durum_n = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sayac          <= '0;
            bolen          <= 16'd4;
            en_r           <= 1'b0;
            tek_r          <= 1'b0;
            par_bit        <= 1'b0;
            bit_idx        <= '0;
            veri_sh        <= '0;
            veri_o         <= '0;
            veri_gecerli_o <= 1'b0;
            cerceve_hata_o <= 1'b0;
            eslik_hata_o   <= 1'b0;
            tasma_o        <= 1'b0;
        end else begin
            // Half-bit initial load puts every later tick at mid-bit.
            if (bas_kenar) begin
                sayac <= (d_eff >> 1) - 16'd1;
                bolen <= d_eff;
                en_r  <= eslik_en_i;
                tek_r <= eslik_tek_i;
            end else if (tick) begin
                sayac <= bolen - 16'd1;
            end else if (durum != BOSTA) begin
                sayac <= sayac - 16'd1;
            end
            if (tick && durum == BASLA)
                bit_idx <= '0;
            if (tick && durum == VERI) begin
                veri_sh[bit_idx] <= rx_s;
                bit_idx          <= bit_idx + IW'(1);
            end
            if (tick && durum == ESLIK)
                par_bit <= rx_s;
            if (yukle)
                veri_o <= veri_sh;
            veri_gecerli_o <= yukle || bekleyen;
            cerceve_hata_o <= ce;
            eslik_hata_o   <= pe;
            tasma_o        <= ov;
        end
    end
endmodule

// File: tb/tb_uart_rx_cozucu.sv
// tb_uart_rx_cozucu: directed bench for uart_rx_cozucu with immediate-assertion checks
module tb_uart_rx_cozucu;
    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [15:0] baud_div_i = 16'd16;
    logic        eslik_en_i = 1'b0;
    logic        eslik_tek_i = 1'b0;
    logic        rx_i = 1'b1;
    logic [7:0]  veri_o;
    logic        veri_gecerli_o;
    logic        veri_hazir_i = 1'b1;
    logic        cerceve_hata_o, eslik_hata_o, tasma_o, mesgul_o;

    int errors = 0;
    int checks = 0;
    int cyc, first_v, first_e, n_v, n_ce, n_pe, n_ov;

    uart_rx_cozucu dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .baud_div_i(baud_div_i),
        .eslik_en_i(eslik_en_i), .eslik_tek_i(eslik_tek_i), .rx_i(rx_i),
        .veri_o(veri_o), .veri_gecerli_o(veri_gecerli_o), .veri_hazir_i(veri_hazir_i),
        .cerceve_hata_o(cerceve_hata_o), .eslik_hata_o(eslik_hata_o),
        .tasma_o(tasma_o), .mesgul_o(mesgul_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; first_v = -1; first_e = -1;
        n_v = 0; n_ce = 0; n_pe = 0; n_ov = 0;
    endtask

    // One clock: outputs are observed on the falling edge after each rising edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        if (veri_gecerli_o) begin
            n_v++;
            if (first_v < 0) first_v = cyc;
        end
        if (cerceve_hata_o) n_ce++;
        if (eslik_hata_o) n_pe++;
        if (tasma_o) n_ov++;
        if ((cerceve_hata_o || eslik_hata_o || tasma_o) && first_e < 0) first_e = cyc;
    endtask

    // Drive one frame (start, data LSB first, optional parity, stop), then tail cycles at idle level.
    task automatic send(input logic [7:0] dat, input bit pen, input bit pb, input bit stp,
                        input int d, input int tail, input bit idle, input int chg);
        logic [10:0] fr;
        int nb;
        fr = pen ? {1'b1, stp, pb, dat, 1'b0} : {1'b1, 1'b1, stp, dat, 1'b0};
        nb = pen ? 11 : 10;
        clr();
        for (int c = 0; c < nb * d + tail; c++) begin
            if (c == chg) baud_div_i = 16'd32;
            rx_i = (c < nb * d) ? fr[c / d] : idle;
            step();
        end
    endtask

    initial begin
        #23;
        chk("rst_valid", veri_gecerli_o, 0);
        chk("rst_data", veri_o, 0);
        chk("rst_busy", mesgul_o, 0);
        chk("rst_err", {cerceve_hata_o, eslik_hata_o, tasma_o}, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (3) @(negedge clk_i);

        // 1: 8N1 0xA5, D=16 -> valid 2 sync clocks + 153 after detect
        send(8'hA5, 0, 0, 1, 16, 18, 1, -1);
        chk("t1_data", veri_o, 8'hA5);
        chk("t1_lat", first_v, 155);
        chk("t1_vcnt", n_v, 1);
        chk("t1_err", n_ce + n_pe + n_ov, 0);
        chk("t1_busy", mesgul_o, 0);

        // 2: even parity, 0x07 has three ones -> parity bit 1
        eslik_en_i = 1'b1; eslik_tek_i = 1'b0;
        send(8'h07, 1, 1, 1, 16, 18, 1, -1);
        chk("t2_data", veri_o, 8'h07);
        chk("t2_lat", first_v, 171);
        chk("t2_pe0", n_pe, 0);
        send(8'h07, 1, 0, 1, 16, 18, 1, -1);
        chk("t2_pe1", n_pe, 1);
        chk("t2_pe_at", first_e, 171);
        chk("t2_nov", n_v, 0);
        eslik_en_i = 1'b0;

        // 3: glitch, then break, then recovery
        clr();
        rx_i = 1'b0;
        repeat (3) step();
        chk("t3_gl_busy", mesgul_o, 1);
        rx_i = 1'b1;
        repeat (30) step();
        chk("t3_gl_out", n_v + n_ce + n_pe + n_ov, 0);
        chk("t3_gl_idle", mesgul_o, 0);
        send(8'h3C, 0, 0, 0, 16, 640, 0, -1);
        chk("t3_ce", n_ce, 1);
        chk("t3_ce_at", first_e, 155);
        chk("t3_brk_v", n_v, 0);
        chk("t3_brk_busy", mesgul_o, 0);
        rx_i = 1'b1;
        repeat (20) step();
        send(8'h55, 0, 0, 1, 16, 18, 1, -1);
        chk("t3_data", veri_o, 8'h55);
        chk("t3_vcnt", n_v, 1);

        // 4: overrun with consumer stalled
        veri_hazir_i = 1'b0;
        send(8'h11, 0, 0, 1, 16, 0, 1, -1);
        chk("t4_lat", first_v, 155);
        chk("t4_data1", veri_o, 8'h11);
        send(8'h22, 0, 0, 1, 16, 18, 1, -1);
        chk("t4_ov", n_ov, 1);
        chk("t4_ov_at", first_e, 155);
        chk("t4_hold", veri_o, 8'h11);
        chk("t4_vhold", veri_gecerli_o, 1);
        veri_hazir_i = 1'b1;
        step();
        chk("t4_drop", veri_gecerli_o, 0);
        chk("t4_keep", veri_o, 8'h11);

        // 5: divider clamp and mid-frame divider change
        baud_div_i = 16'd1;
        send(8'h9C, 0, 0, 1, 4, 6, 1, -1);
        chk("t5_d4_data", veri_o, 8'h9C);
        chk("t5_d4_lat", first_v, 41);
        baud_div_i = 16'd16;
        send(8'h6B, 0, 0, 1, 16, 18, 1, 40);
        chk("t5_chg_data", veri_o, 8'h6B);
        chk("t5_chg_lat", first_v, 155);
        baud_div_i = 16'd16;

        // 6: reset mid-frame
        clr();
        rx_i = 1'b0;
        repeat (40) step();
        chk("t6_busy", mesgul_o, 1);
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_data", veri_o, 0);
        chk("t6_rst_valid", veri_gecerli_o, 0);
        chk("t6_rst_busy", mesgul_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        rx_i = 1'b1;
        repeat (5) step();
        send(8'hF0, 0, 0, 1, 16, 18, 1, -1);
        chk("t6_data", veri_o, 8'hF0);
        chk("t6_lat", first_v, 155);
        chk("t6_err", n_ce + n_pe + n_ov, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
